// File: rtl/output_gpio_stream.sv
// Pixel output streamer: accepts LANES-wide pixel words over valid/ready and
// serialises them one pixel per transfer, each tagged with its frame address.
module output_gpio_stream #(
    parameter int PIXEL_W = 8,
    parameter int LANES   = 4,
    parameter int IMG_W   = 400,
    parameter int IMG_H   = 400,
    parameter int ADDR_W  = 18,
    parameter int REVERSE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [LANES*PIXEL_W-1:0]   in_data,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [PIXEL_W-1:0]         out_pixel,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       busy,
    output logic                       done
);

    localparam int     TOTAL    = IMG_W * IMG_H;
    localparam int     LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam longint CAPACITY = 64'd1 << ADDR_W;
    localparam longint NEEDED   = longint'(IMG_W) * longint'(IMG_H);

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = (REVERSE != 0) ? ADDR_W'(TOTAL - 1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] FINAL_ADDR = (REVERSE != 0) ? ADDR_W'(0) : ADDR_W'(TOTAL - 1);

    if (LANES < 1) begin : g_badLanes
        $error("output_gpio_stream: LANES must be at least 1");
    end
    if (CAPACITY < NEEDED) begin : g_badAddrW
        $error("output_gpio_stream: ADDR_W too small for IMG_W*IMG_H");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [LANES*PIXEL_W-1:0]   pixelBuf_q, pixelBuf_d;
    logic                       full_q, full_d;
    logic [LANE_W-1:0]          laneIdx_q, laneIdx_d;
    logic [ADDR_W-1:0]          addrCnt_q, addrCnt_d;

    logic xfer;
    logic accept;
    logic lastLane;
    logic lastPixel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pixelBuf_q <= '0;
            full_q     <= 1'b0;
            laneIdx_q  <= '0;
            addrCnt_q  <= FIRST_ADDR;
        end else begin
            state_q    <= state_d;
            pixelBuf_q <= pixelBuf_d;
            full_q     <= full_d;
            laneIdx_q  <= laneIdx_d;
            addrCnt_q  <= addrCnt_d;
        end
    end

    // The buffer shifts down one lane per transfer, so lane 0 of the live
    // word is always in the low bits.
    always_comb begin
        out_valid = (state_q == S_RUN) && full_q;
        out_pixel = out_valid ? pixelBuf_q[PIXEL_W-1:0] : '0;
        out_addr  = out_valid ? addrCnt_q : '0;
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);

        xfer      = out_valid && out_ready;
        lastLane  = (laneIdx_q == LAST_LANE);
        lastPixel = (addrCnt_q == FINAL_ADDR);

        // Refill during the last-lane transfer keeps one pixel per cycle, but
        // never past the final pixel of the frame.
        in_ready  = (state_q == S_RUN) && (!full_q || (xfer && lastLane && !lastPixel));
        accept    = in_valid && in_ready;
    end

    always_comb begin
        state_d    = state_q;
        pixelBuf_d = pixelBuf_q;
        full_d     = full_q;
        laneIdx_d  = laneIdx_q;
        addrCnt_d  = addrCnt_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    addrCnt_d = FIRST_ADDR;
                    full_d    = 1'b0;
                    laneIdx_d = '0;
                end
            end

            S_RUN: begin
                if (xfer && lastPixel) begin
                    // Any lanes left over after the final pixel are dropped.
                    state_d   = S_DONE;
                    full_d    = 1'b0;
                    laneIdx_d = '0;
                end else begin
                    if (xfer) begin
                        if (REVERSE != 0) begin
                            addrCnt_d = addrCnt_q - ADDR_W'(1);
                        end else begin
                            addrCnt_d = addrCnt_q + ADDR_W'(1);
                        end
                        pixelBuf_d = pixelBuf_q >> PIXEL_W;
                        if (lastLane) begin
                            full_d    = 1'b0;
                            laneIdx_d = '0;
                        end else begin
                            laneIdx_d = laneIdx_q + LANE_W'(1);
                        end
                    end
                    if (accept) begin
                        pixelBuf_d = in_data;
                        full_d     = 1'b1;
                        laneIdx_d  = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_output_gpio_stream.sv
// Testbench for output_gpio_stream: three instances (4x2, 3x2 with a tail,
// 4x2 reversed) share one stimulus stream and are checked against expectations.
module tb_output_gpio_stream;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;

    logic        aReady, aValid, aBusy, aDone;
    logic [7:0]  aPixel;
    logic [17:0] aAddr;
    logic        bReady, bValid, bBusy, bDone;
    logic [7:0]  bPixel;
    logic [17:0] bAddr;
    logic        cReady, cValid, cBusy, cDone;
    logic [7:0]  cPixel;
    logic [17:0] cAddr;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic        start;
        logic        inValid;
        logic [31:0] inData;
        logic        outReady;
        logic        expReady;
        logic        expValid;
        logic [7:0]  expPixel;
        logic [17:0] expAddr;
        logic [17:0] expAddrRev;
        logic        expBusy;
        logic        expDone;
        logic        expValidB;
        logic        expDoneB;
    } vec_t;

    vec_t vecs[$];

    output_gpio_stream #(.PIXEL_W(8), .LANES(4), .IMG_W(4), .IMG_H(2), .ADDR_W(18), .REVERSE(0)) dutA (
        .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_data(inData),
        .in_ready(aReady), .out_ready(outReady), .out_valid(aValid), .out_pixel(aPixel),
        .out_addr(aAddr), .busy(aBusy), .done(aDone)
    );

    output_gpio_stream #(.PIXEL_W(8), .LANES(4), .IMG_W(3), .IMG_H(2), .ADDR_W(18), .REVERSE(0)) dutB (
        .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_data(inData),
        .in_ready(bReady), .out_ready(outReady), .out_valid(bValid), .out_pixel(bPixel),
        .out_addr(bAddr), .busy(bBusy), .done(bDone)
    );

    output_gpio_stream #(.PIXEL_W(8), .LANES(4), .IMG_W(4), .IMG_H(2), .ADDR_W(18), .REVERSE(1)) dutC (
        .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_data(inData),
        .in_ready(cReady), .out_ready(outReady), .out_valid(cValid), .out_pixel(cPixel),
        .out_addr(cAddr), .busy(cBusy), .done(cDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        inValid  = v.inValid;
        inData   = v.inData;
        outReady = v.outReady;
    endtask

    task automatic addVec(input logic st, input logic iv, input logic [31:0] d,
                          input logic rdy, input logic vld, input logic [7:0] px,
                          input logic [17:0] ad, input logic [17:0] adRev,
                          input logic bz, input logic dn, input logic vldB, input logic dnB);
        vec_t v;
        v.start = st; v.inValid = iv; v.inData = d; v.outReady = 1'b1;
        v.expReady = rdy; v.expValid = vld; v.expPixel = px;
        v.expAddr = ad; v.expAddrRev = adRev; v.expBusy = bz; v.expDone = dn;
        v.expValidB = vldB; v.expDoneB = dnB;
        vecs.push_back(v);
    endtask

    // The 3x2 instance tracks the 4x2 one until its own frame ends early.
    task automatic checkRow(input int i, input vec_t v);
        checkOutput($sformatf("r%0d aReady", i), 32'(aReady), 32'(v.expReady));
        checkOutput($sformatf("r%0d aValid", i), 32'(aValid), 32'(v.expValid));
        checkOutput($sformatf("r%0d aPixel", i), 32'(aPixel), 32'(v.expPixel));
        checkOutput($sformatf("r%0d aAddr", i),  32'(aAddr),  32'(v.expAddr));
        checkOutput($sformatf("r%0d aBusy", i),  32'(aBusy),  32'(v.expBusy));
        checkOutput($sformatf("r%0d aDone", i),  32'(aDone),  32'(v.expDone));
        checkOutput($sformatf("r%0d bValid", i), 32'(bValid), 32'(v.expValidB));
        checkOutput($sformatf("r%0d bPixel", i), 32'(bPixel), v.expValidB ? 32'(v.expPixel) : 32'd0);
        checkOutput($sformatf("r%0d bAddr", i),  32'(bAddr),  v.expValidB ? 32'(v.expAddr) : 32'd0);
        checkOutput($sformatf("r%0d bReady", i), 32'(bReady), 32'(v.expReady && !v.expDoneB));
        checkOutput($sformatf("r%0d bBusy", i),  32'(bBusy),  32'(v.expBusy && !v.expDoneB));
        checkOutput($sformatf("r%0d bDone", i),  32'(bDone),  32'(v.expDoneB));
        checkOutput($sformatf("r%0d cReady", i), 32'(cReady), 32'(v.expReady));
        checkOutput($sformatf("r%0d cValid", i), 32'(cValid), 32'(v.expValid));
        checkOutput($sformatf("r%0d cPixel", i), 32'(cPixel), 32'(v.expPixel));
        checkOutput($sformatf("r%0d cAddr", i),  32'(cAddr),  32'(v.expAddrRev));
        checkOutput($sformatf("r%0d cDone", i),  32'(cDone),  32'(v.expDone));
    endtask

    // Runs one full frame with a repeating out_ready pattern and an optional
    // start pulse while the frame is in progress; pixel n must sit at address n.
    task automatic runFrame(input logic [3:0] pat, input int pulseAt);
        int  idx = 0;
        int  bIdx = 0;
        int  cIdx = 0;
        int  wordIdx = 0;
        bit  pulsed = 0;
        bit  finished = 0;
        for (int c = 0; c < 100 && !finished; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (c > 0 && pulseAt >= 0 && !pulsed && idx == pulseAt) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            inValid  = (wordIdx < 2);
            inData   = (wordIdx == 0) ? 32'h03020100 : ((wordIdx == 1) ? 32'h07060504 : 32'h0);
            outReady = pat[c % 4];
            #1;
            if (c > 0 && aDone) begin
                finished = 1'b1;
            end else begin
                if (aValid) begin
                    checkOutput($sformatf("frame a pixel %0d", idx), 32'(aPixel), 32'(idx[7:0]));
                    checkOutput($sformatf("frame a addr %0d", idx), 32'(aAddr), 32'(idx));
                    if (outReady) idx++;
                end
                if (cValid) begin
                    checkOutput($sformatf("frame c pixel %0d", cIdx), 32'(cPixel), 32'(cIdx[7:0]));
                    checkOutput($sformatf("frame c addr %0d", cIdx), 32'(cAddr), 32'(7 - cIdx));
                    if (outReady) cIdx++;
                end
                if (bValid) begin
                    checkOutput($sformatf("frame b pixel %0d", bIdx), 32'(bPixel), 32'(bIdx[7:0]));
                    checkOutput($sformatf("frame b addr %0d", bIdx), 32'(bAddr), 32'(bIdx));
                    if (outReady) bIdx++;
                end
                if (inValid && aReady) wordIdx++;
            end
        end
        checkOutput("frame finished", 32'(finished), 32'd1);
        checkOutput("frame a transfers", 32'(idx), 32'd8);
        checkOutput("frame c transfers", 32'(cIdx), 32'd8);
        checkOutput("frame b transfers", 32'(bIdx), 32'd6);
        checkOutput("frame a busy after", 32'(aBusy), 32'd0);
        checkOutput("frame b done after", 32'(bDone), (pulseAt < 6) ? 32'd1 : 32'd0);
    endtask

    task automatic resetMidFrame();
        int wordIdx = 0;
        bit hit = 0;
        @(negedge clk);
        start = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start   = 1'b0;
            inValid = (wordIdx < 2);
            inData  = (wordIdx == 0) ? 32'h03020100 : 32'h07060504;
            #1;
            if (aValid && aAddr == 18'd5) begin
                hit = 1'b1;
                break;
            end
            if (inValid && aReady) wordIdx++;
        end
        checkOutput("reset reached addr 5", 32'(hit), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async reset aValid", 32'(aValid), 32'd0);
        checkOutput("async reset aPixel", 32'(aPixel), 32'd0);
        checkOutput("async reset aAddr", 32'(aAddr), 32'd0);
        checkOutput("async reset aBusy", 32'(aBusy), 32'd0);
        checkOutput("async reset aReady", 32'(aReady), 32'd0);
        checkOutput("async reset bValid", 32'(bValid), 32'd0);
        checkOutput("async reset cAddr", 32'(cAddr), 32'd0);
        @(negedge clk);
        rst = 1'b1; inValid = 1'b0; inData = '0;
        @(negedge clk);
        #1;
        checkOutput("post reset idle busy", 32'(aBusy), 32'd0);
        checkOutput("post reset idle done", 32'(aDone), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b1;
        #1;
        checkOutput("reset aValid", 32'(aValid), 32'd0);
        checkOutput("reset aReady", 32'(aReady), 32'd0);
        checkOutput("reset aBusy", 32'(aBusy), 32'd0);
        checkOutput("reset aDone", 32'(aDone), 32'd0);
        checkOutput("reset cAddr", 32'(cAddr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back words at full rate; start pulsed mid-frame (row 7) is the
        // final-transfer cycle for the 3x2 instance.
        //     st iv data          rdy vld px     ad     adRev  bz dn vB dB
        addVec(1, 0, 32'h0,        0,  0,  8'h00, 18'd0, 18'd0, 0, 0, 0, 0);
        addVec(0, 1, 32'h03020100, 1,  0,  8'h00, 18'd0, 18'd0, 1, 0, 0, 0);
        addVec(0, 1, 32'h07060504, 0,  1,  8'h00, 18'd0, 18'd7, 1, 0, 1, 0);
        addVec(0, 1, 32'h07060504, 0,  1,  8'h01, 18'd1, 18'd6, 1, 0, 1, 0);
        addVec(0, 1, 32'h07060504, 0,  1,  8'h02, 18'd2, 18'd5, 1, 0, 1, 0);
        addVec(0, 1, 32'h07060504, 1,  1,  8'h03, 18'd3, 18'd4, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h04, 18'd4, 18'd3, 1, 0, 1, 0);
        addVec(1, 0, 32'h0,        0,  1,  8'h05, 18'd5, 18'd2, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h06, 18'd6, 18'd1, 1, 0, 0, 1);
        addVec(0, 0, 32'h0,        0,  1,  8'h07, 18'd7, 18'd0, 1, 0, 0, 1);
        addVec(0, 0, 32'h0,        0,  0,  8'h00, 18'd0, 18'd0, 0, 1, 0, 1);
        // Restart from DONE, then a three-cycle input gap between words.
        addVec(1, 0, 32'h0,        0,  0,  8'h00, 18'd0, 18'd0, 0, 1, 0, 1);
        addVec(0, 1, 32'h03020100, 1,  0,  8'h00, 18'd0, 18'd0, 1, 0, 0, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h00, 18'd0, 18'd7, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h01, 18'd1, 18'd6, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h02, 18'd2, 18'd5, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        1,  1,  8'h03, 18'd3, 18'd4, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        1,  0,  8'h00, 18'd0, 18'd0, 1, 0, 0, 0);
        addVec(0, 0, 32'h0,        1,  0,  8'h00, 18'd0, 18'd0, 1, 0, 0, 0);
        addVec(0, 0, 32'h0,        1,  0,  8'h00, 18'd0, 18'd0, 1, 0, 0, 0);
        addVec(0, 1, 32'h07060504, 1,  0,  8'h00, 18'd0, 18'd0, 1, 0, 0, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h04, 18'd4, 18'd3, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h05, 18'd5, 18'd2, 1, 0, 1, 0);
        addVec(0, 0, 32'h0,        0,  1,  8'h06, 18'd6, 18'd1, 1, 0, 0, 1);
        addVec(0, 0, 32'h0,        0,  1,  8'h07, 18'd7, 18'd0, 1, 0, 0, 1);
        addVec(0, 0, 32'h0,        0,  0,  8'h00, 18'd0, 18'd0, 0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkRow(i, vecs[i]);
        end

        runFrame(4'b1001, -1);
        runFrame(4'b1111, 7);
        resetMidFrame();
        runFrame(4'b1111, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/output_gpio_stream.md
Name: output_gpio_stream

Overview:
Parametrised pixel output streamer that follows the single-pixel GPIO output block. It accepts LANES-wide pixel words from the vector datapath through a valid/ready handshake and serialises them, one pixel per transfer, onto the GPIO pixel pins. Each pixel carries a frame address. A start/done frame protocol and a selectable address direction are provided.

Parameters:
PIXEL_W, 8, bits per pixel
LANES, 4, pixels per input word (>=1)
IMG_W, 400, frame width in pixels
IMG_H, 400, frame height in pixels
ADDR_W, 18, address width; elaboration error if 2**ADDR_W < IMG_W*IMG_H
REVERSE, 0, 0 = address counts 0 up to TOTAL-1; 1 = address counts TOTAL-1 down to 0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  single-cycle frame start request
in_valid  in  1  in_data holds a valid word
in_data  in  LANES*PIXEL_W  pixel word; lane k = bits [k*PIXEL_W +: PIXEL_W]; lane 0 is emitted first
in_ready  out  1  block accepts in_data this cycle
out_ready  in  1  GPIO consumer accepts out_pixel
out_valid  out  1  out_pixel/out_addr valid
out_pixel  out  PIXEL_W  current pixel
out_addr  out  ADDR_W  frame address of out_pixel
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- TOTAL = IMG_W*IMG_H. A transfer occurs when out_valid && out_ready. An accept occurs when in_valid && in_ready.
- Reset (rst=0, asynchronous):
  - state=IDLE, buffer empty, lane index=0, address counter = 0 (REVERSE=0) or TOTAL-1 (REVERSE=1).
  - All outputs 0.
  - Reset mid-frame aborts immediately; the partial frame is lost.
- States:
  - IDLE: in_ready=0, out_valid=0. start=1 -> RUN, and the address counter loads its initial value.
  - RUN: busy=1. Exits to DONE on the transfer of the final pixel (address TOTAL-1 when REVERSE=0, address 0 when REVERSE=1). start is ignored in RUN.
  - DONE: done=1, in_ready=0, out_valid=0. start=1 -> RUN with the counter reloaded and done cleared on the next cycle. Otherwise DONE holds.
- Buffer:
  - One LANES-pixel word register plus a lane index.
  - in_ready (RUN only) = buffer empty OR (transfer this cycle AND lane index = LANES-1). This gives full throughput of one pixel per cycle with no refill bubble.
  - Latency: a word accepted at edge N has lane 0 on out_pixel with out_valid=1 after edge N.
  - The lane index advances on each transfer. After lane LANES-1, the buffer empties unless a refill is accepted in the same cycle, in which case the index goes to 0 with the new word.
- Output stability: while out_valid=1 and out_ready=0, out_pixel and out_addr hold.
- Output zeroing: when out_valid=0, out_pixel=0 and out_addr=0.
- Address:
  - out_addr = counter while out_valid.
  - The counter steps +1 (REVERSE=0) or -1 (REVERSE=1) per transfer only. It never wraps within a frame.
- Tail: if TOTAL mod LANES != 0, lanes remaining in the buffer after the final pixel are discarded on entry to DONE, and no further words are accepted.
- Edge cases:
  - in_valid low in RUN with the buffer empty: out_valid=0 (bubble); counter unchanged.
  - start asserted in the same cycle as the final transfer: ignored; the block enters DONE.

Test Plan:
- LANES=4, IMG 4x2, REVERSE=0, out_ready=1. start, then words 0x03020100 and 0x07060504 back-to-back -> out_pixel 00..07 on consecutive cycles, out_addr 0..7, in_ready high at the lane-3 transfer, done=1 the cycle after address 7, busy=0.
- Same config, out_ready toggles 1,0,0,1... -> out_pixel/out_addr stable during stalls, no pixel skipped or duplicated, 8 transfers total.
- IMG 3x2 (TOTAL=6), LANES=4. Words 0x03020100, 0x07060504 -> pixels 00..05 at addresses 0..5. Lanes 06,07 discarded, DONE entered, in_ready=0 thereafter.
- REVERSE=1, IMG 4x2 -> first transfer at out_addr 7 descending to 0. done after address 0.
- in_valid low for 3 cycles between words -> out_valid=0, out_pixel=0, out_addr=0 during the gap; addresses continue 4,5.. with no gap.
- rst pulled low mid-frame at address 5 -> all outputs 0 asynchronously, state IDLE. A new start restarts at address 0. start pulsed mid-RUN -> no effect on address sequence.
